// File: rtl/tt_mask_idx_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tt_mask_idx_gen: emits v0 mask chunks (strided ops) or per-element index
// items (indexed ops) to the LSU mask/index credit interface.   Revision: 1.0
// ----------------------------------------------------------------------------
module tt_mask_idx_gen #(
  parameter int VLEN         = 256,
  parameter int IDX_BEATS    = 8,
  parameter int MASK_CREDITS = 2,
  parameter int IDX_W        = 64
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_start,
  input  logic                        i_abort,
  input  logic                        i_is_masked,
  input  logic                        i_is_indexed,
  input  logic [$clog2(VLEN*8+1)-1:0] i_vl,
  input  logic [1:0]                  i_eew,
  input  logic [VLEN-1:0]             i_mask_data,
  input  logic [VLEN-1:0]             i_index_data,
  input  logic                        i_index_valid,
  output logic                        o_index_ready,
  input  logic                        i_credit,
  output logic                        o_item_valid,
  output logic [IDX_W:0]              o_item,
  output logic                        o_item_last,
  output logic                        o_busy
);
  localparam int VL_W   = $clog2(VLEN*8+1);
  localparam int LOG2V  = $clog2(VLEN);
  localparam int NCHUNK = VLEN / 64;
  localparam int CH_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int EB_W   = LOG2V - 3;
  localparam int NB_W   = VL_W + 7;
  localparam int CR_W   = $clog2(MASK_CREDITS + 1);
  localparam int FP_W   = (IDX_BEATS > 1) ? $clog2(IDX_BEATS) : 1;
  localparam int FC_W   = $clog2(IDX_BEATS + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DRAIN = 2'd2} state_t;
  state_t state, state_n;

  logic [VLEN-1:0]  mask_q;
  logic [VL_W-1:0]  vl_q, items_left;
  logic [1:0]       eew_q;
  logic             indexed_q;
  logic [CH_W-1:0]  chunk_idx;
  logic [LOG2V-1:0] elem_idx;
  logic [EB_W-1:0]  elem_in_beat;
  logic [NB_W-1:0]  beats_needed, beats_rcvd;
  logic [CR_W-1:0]  credits;
  logic [VLEN-1:0]  fifo_mem [IDX_BEATS];
  logic [FP_W-1:0]  wr_ptr, rd_ptr;
  logic [FC_W-1:0]  fifo_cnt;

  logic             start_ok, issue, push, pop, last_issue;
  logic [VLEN-1:0]  head;
  logic [LOG2V-1:0] idx_shamt;
  logic [63:0]      idx_raw, idx_val, chunk_raw, tail_mask;
  logic [VL_W-1:0]  chunk_base, remaining, chunks_req, total_start;
  logic [VL_W:0]    vl_plus;
  logic [NB_W-1:0]  vl_bits, beats_start;
  logic [EB_W-1:0]  epb_last;
  logic [IDX_W:0]   item_n;

  assign o_busy = (state != IDLE);

  assign start_ok = (state == IDLE) && i_start && !i_abort && (i_vl != '0)
                    && (i_is_masked || i_is_indexed);
  assign vl_plus     = {1'b0, i_vl} + (VL_W+1)'(63);
  assign chunks_req  = VL_W'(vl_plus >> 6);
  assign total_start = i_is_indexed ? i_vl :
                       ((chunks_req > VL_W'(NCHUNK)) ? VL_W'(NCHUNK) : chunks_req);
  assign vl_bits     = (NB_W'(i_vl) << 3) << i_eew;
  assign beats_start = (vl_bits + NB_W'(VLEN - 1)) >> LOG2V;

  assign o_index_ready = (state == SEND) && indexed_q && (fifo_cnt != FC_W'(IDX_BEATS))
                         && (beats_rcvd < beats_needed);
  assign push       = i_index_valid && o_index_ready;
  assign issue      = (state == SEND) && !i_abort && (items_left != '0) && (credits != '0)
                      && (!indexed_q || (fifo_cnt != '0));
  assign last_issue = issue && (items_left == VL_W'(1));
  assign epb_last   = EB_W'(((VLEN / 8) >> eew_q) - 1);
  // A beat is retired after its final element, or early when the op ends mid-beat.
  assign pop        = issue && indexed_q && ((elem_in_beat == epb_last) || last_issue);

  assign head       = fifo_mem[rd_ptr];
  assign idx_shamt  = LOG2V'({elem_in_beat, 3'b000} << eew_q);
  assign idx_raw    = 64'(head >> idx_shamt);
  assign chunk_raw  = 64'(mask_q >> {chunk_idx, 6'b000000});
  assign chunk_base = VL_W'({chunk_idx, 6'b000000});
  assign remaining  = vl_q - chunk_base;
  assign tail_mask  = (remaining >= VL_W'(64)) ? '1 : ((64'd1 << remaining) - 64'd1);

  always_comb begin
    idx_val = '0;
    case (eew_q)
      2'd0:    idx_val = {56'd0, idx_raw[7:0]};
      2'd1:    idx_val = {48'd0, idx_raw[15:0]};
      2'd2:    idx_val = {32'd0, idx_raw[31:0]};
      default: idx_val = idx_raw;
    endcase
    // Element mask bits beyond VLEN wrap onto v0 (elem_idx is LOG2V bits wide).
    item_n = indexed_q ? {mask_q[elem_idx], IDX_W'(idx_val)}
                       : {1'b0, IDX_W'(chunk_raw & tail_mask)};
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start_ok) state_n = SEND;
      SEND:    if (last_issue) state_n = DRAIN;
      DRAIN:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (i_abort) state_n = IDLE;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_n;
  end

  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_ptr] <= i_index_data;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_item_valid <= 1'b0;
      o_item       <= '0;
      o_item_last  <= 1'b0;
      credits      <= CR_W'(MASK_CREDITS);
      mask_q       <= '0;
      vl_q         <= '0;
      eew_q        <= '0;
      indexed_q    <= 1'b0;
      items_left   <= '0;
      chunk_idx    <= '0;
      elem_idx     <= '0;
      elem_in_beat <= '0;
      beats_needed <= '0;
      beats_rcvd   <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
    end else begin
      o_item_valid <= issue;
      o_item       <= issue ? item_n : '0;
      o_item_last  <= last_issue;

      if (i_credit && !issue)
        credits <= (credits == CR_W'(MASK_CREDITS)) ? credits : credits + 1'b1;
      else if (!i_credit && issue)
        credits <= credits - 1'b1;

      if (i_abort || start_ok) begin
        items_left   <= i_abort ? '0 : total_start;
        chunk_idx    <= '0;
        elem_idx     <= '0;
        elem_in_beat <= '0;
        beats_rcvd   <= '0;
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        fifo_cnt     <= '0;
        if (start_ok) begin
          mask_q       <= i_is_masked ? i_mask_data : '1;
          vl_q         <= i_vl;
          eew_q        <= i_eew;
          indexed_q    <= i_is_indexed;
          beats_needed <= beats_start;
        end
      end else begin
        if (push) begin
          wr_ptr     <= (wr_ptr == FP_W'(IDX_BEATS - 1)) ? '0 : wr_ptr + 1'b1;
          beats_rcvd <= beats_rcvd + 1'b1;
        end
        if (pop) rd_ptr <= (rd_ptr == FP_W'(IDX_BEATS - 1)) ? '0 : rd_ptr + 1'b1;
        if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
        else if (!push && pop) fifo_cnt <= fifo_cnt - 1'b1;
        if (issue) begin
          items_left <= items_left - 1'b1;
          if (indexed_q) begin
            elem_idx     <= elem_idx + 1'b1;
            elem_in_beat <= pop ? '0 : elem_in_beat + 1'b1;
          end else begin
            chunk_idx <= chunk_idx + 1'b1;
          end
        end
      end
    end
  end

  credit_overflow_a: assert property (@(posedge i_clk) disable iff (!i_reset_n)
      !(i_credit && !issue && (credits == CR_W'(MASK_CREDITS))))
    else $error("credit returned while already at MASK_CREDITS");

endmodule
`default_nettype wire

// File: tb/tb_tt_mask_idx_gen.sv
`default_nettype none
// tb_tt_mask_idx_gen: directed bench; expected items are queued at op start
// and compared in order as the generator emits them.
module tb_tt_mask_idx_gen;
  localparam int VLEN = 256;
  localparam int VL_W = $clog2(VLEN*8+1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, abort_op, is_masked, is_indexed, index_valid, index_ready;
  logic             credit, item_valid, item_last, busy;
  logic [VL_W-1:0]  vl;
  logic [1:0]       eew;
  logic [VLEN-1:0]  mask_data, index_data;
  logic [64:0]      item;

  tt_mask_idx_gen #(.VLEN(VLEN), .IDX_BEATS(8), .MASK_CREDITS(2), .IDX_W(64)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_abort(abort_op),
    .i_is_masked(is_masked), .i_is_indexed(is_indexed), .i_vl(vl), .i_eew(eew),
    .i_mask_data(mask_data), .i_index_data(index_data), .i_index_valid(index_valid),
    .o_index_ready(index_ready), .i_credit(credit), .o_item_valid(item_valid),
    .o_item(item), .o_item_last(item_last), .o_busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [64:0] data; logic last; } exp_t;
  exp_t q[$];

  int checks = 0, errors = 0;
  int items_seen = 0, owed = 0, manual = 0, beats_acc = 0, beats_to_send = 0;
  int cur_eew = 0, base = 0, n = 0;
  bit auto_credit = 1'b0;
  logic [VLEN-1:0] rmask;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] idx_pat(input int k);
    if (k == 19) return 64'hFFFF;
    return 64'(k * 4);
  endfunction

  function automatic logic [63:0] wmask_of(input int e);
    if (e == 3) return '1;
    return (64'd1 << (8 << e)) - 64'd1;
  endfunction

  function automatic logic [VLEN-1:0] make_beat(input int b);
    logic [VLEN-1:0] beat;
    int w, epb;
    w = 8 << cur_eew;
    epb = VLEN / w;
    beat = '0;
    for (int j = 0; j < epb; j++)
      beat |= VLEN'(idx_pat(b * epb + j) & wmask_of(cur_eew)) << (j * w);
    return beat;
  endfunction

  function automatic logic [VLEN-1:0] rand256();
    logic [VLEN-1:0] r;
    for (int i = 0; i < VLEN / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    logic hs;
    exp_t e;
    hs = index_valid && index_ready;
    @(posedge clk);
    #1;
    if (hs) begin
      beats_acc++;
      if (beats_acc < beats_to_send) index_data = make_beat(beats_acc);
      else index_valid = 1'b0;
    end
    if (item_valid) begin
      items_seen++;
      owed++;
      if (q.size() == 0) begin
        check("unexpected_item", {64'd0, item_valid}, 65'd0);
      end else begin
        e = q.pop_front();
        check("item_data", item, e.data);
        check("item_last", {64'd0, item_last}, {64'd0, e.last});
      end
    end
    if ((auto_credit && owed > 0) || manual > 0) begin
      credit = 1'b1;
      owed--;
      if (manual > 0) manual--;
    end else begin
      credit = 1'b0;
    end
  endtask

  task automatic start_op(input bit m, input bit ix, input int vlen_el, input int e,
                          input logic [VLEN-1:0] msk);
    logic [VLEN-1:0] effm;
    logic [63:0] chunk;
    int nch;
    effm = m ? msk : '1;
    is_masked = m; is_indexed = ix; vl = VL_W'(vlen_el); eew = 2'(e);
    mask_data = msk; start = 1'b1;
    if (vlen_el > 0 && (m || ix)) begin
      if (ix) begin
        cur_eew = e;
        for (int k = 0; k < vlen_el; k++)
          q.push_back({effm[k % VLEN], idx_pat(k) & wmask_of(e), k == vlen_el - 1});
        beats_to_send = (vlen_el * (8 << e) + VLEN - 1) / VLEN;
        beats_acc = 0;
        index_data = make_beat(0);
        index_valid = 1'b1;
      end else begin
        nch = (vlen_el + 63) / 64;
        if (nch > VLEN / 64) nch = VLEN / 64;
        for (int c = 0; c < nch; c++) begin
          chunk = 64'(effm >> (c * 64));
          for (int b = 0; b < 64; b++) if (c * 64 + b >= vlen_el) chunk[b] = 1'b0;
          q.push_back({1'b0, chunk, c == nch - 1});
        end
      end
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_items(input string tag, input int limit);
    int cnt = 0;
    while (q.size() != 0 && cnt < limit) begin
      tick();
      cnt++;
    end
    check(tag, 65'(q.size()), 65'd0);
  endtask

  task automatic settle();
    auto_credit = 1'b1;
    repeat (6) tick();
  endtask

  initial begin
    rst_n = 1'b0; start = 0; abort_op = 0; is_masked = 0; is_indexed = 0;
    vl = '0; eew = '0; mask_data = '0; index_data = '0; index_valid = 0; credit = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {64'd0, item_valid}, 65'd0);
    check("rst_item", item, 65'd0);
    check("rst_last", {64'd0, item_last}, 65'd0);
    check("rst_ready", {64'd0, index_ready}, 65'd0);
    check("rst_busy", {64'd0, busy}, 65'd0);
    check("rst_credits", 65'(dut.credits), 65'd2);
    rst_n = 1'b1;
    tick();

    // Strided, vl=130, unit latency and tail clear on the third chunk
    auto_credit = 1'b1;
    start_op(1'b1, 1'b0, 130, 0, '1);
    check("lat_n1_valid", {64'd0, item_valid}, 65'd0);
    check("lat_n1_busy", {64'd0, busy}, 65'd1);
    tick();
    check("lat_n2_valid", {64'd0, item_valid}, 65'd1);
    wait_items("strided130_done", 20);
    check("drain_busy", {64'd0, busy}, 65'd1);
    tick();
    check("idle_after_last", {64'd0, busy}, 65'd0);
    settle();

    // vl=0 and non-masked/non-indexed starts are ignored
    start_op(1'b1, 1'b0, 0, 0, '1);
    repeat (3) begin tick(); check("vl0_busy", {64'd0, busy}, 65'd0); end
    start_op(1'b0, 1'b0, 10, 0, '1);
    repeat (3) begin tick(); check("plain_busy", {64'd0, busy}, 65'd0); end

    // Credit starvation
    auto_credit = 1'b0;
    base = items_seen;
    rmask = rand256();
    start_op(1'b1, 1'b0, 256, 0, rmask);
    repeat (10) tick();
    check("starve_two", 65'(items_seen - base), 65'd2);
    manual = 1;
    repeat (10) tick();
    check("starve_three", 65'(items_seen - base), 65'd3);
    manual = 1;
    wait_items("starve_done", 10);
    settle();

    // Abort mid-SEND
    base = items_seen;
    start_op(1'b1, 1'b0, 256, 0, rand256());
    n = 0;
    while (items_seen - base < 1 && n < 20) begin tick(); n++; end
    abort_op = 1'b1;
    tick();
    abort_op = 1'b0;
    q.delete();
    tick();
    check("abort_valid", {64'd0, item_valid}, 65'd0);
    check("abort_busy", {64'd0, busy}, 65'd0);
    check("abort_fifo", 65'(dut.fifo_cnt), 65'd0);
    tick();
    check("abort_valid2", {64'd0, item_valid}, 65'd0);
    settle();

    // Indexed unmasked, eew=16b, vl=20, zero extension of 0xFFFF
    start_op(1'b0, 1'b1, 20, 1, '0);
    wait_items("idx20_done", 200);
    check("idx20_beats", 65'(beats_acc), 65'd2);
    settle();

    // Indexed masked, eew=8b, vl=2048: FIFO fills at 8 beats
    auto_credit = 1'b0;
    base = items_seen;
    start_op(1'b1, 1'b1, 2048, 0, rand256());
    repeat (20) tick();
    check("fill_beats", 65'(beats_acc), 65'd8);
    check("fill_ready_low", {64'd0, index_ready}, 65'd0);
    check("fill_items", 65'(items_seen - base), 65'd2);
    auto_credit = 1'b1;
    wait_items("idx2048_done", 12000);
    check("idx2048_beats", 65'(beats_acc), 65'd64);
    settle();

    // Asynchronous reset mid-SEND
    start_op(1'b1, 1'b0, 256, 0, rand256());
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {64'd0, item_valid}, 65'd0);
    check("arst_item", item, 65'd0);
    check("arst_busy", {64'd0, busy}, 65'd0);
    check("arst_credits", 65'(dut.credits), 65'd2);
    q.delete();
    owed = 0; manual = 0; index_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    start_op(1'b1, 1'b0, 64, 0, rand256());
    wait_items("post_reset_done", 20);
    settle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
